axis_frame_len_stats: RTL and testbench

- Downstream consumer of the frame length measurement stage. Takes its one-cycle frame_len/frame_len_valid strobe and accumulates per-interval frame statistics: frame count, byte/word total, min length, max length, runt count and oversize count.
- On request, it atomically snapshots the accumulators and clears them. The snapshot is presented on a valid/ready status port for a CSR or telemetry block.

---
 rtl/axis_frame_len_stats.sv | 221 ++++++++++++++++++++++
 tb/tb_axis_frame_len_stats.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/axis_frame_len_stats.sv
// axis_frame_len_stats
// Accumulates per-interval frame statistics from a one-cycle frame length
// strobe and, on request, atomically snapshots and clears them. The snapshot
// is offered on a valid/ready status port and held stable until the next
// capture.
module axis_frame_len_stats #(
    parameter int LEN_WIDTH        = 16,
    parameter int COUNT_WIDTH      = 32,
    parameter int BYTE_COUNT_WIDTH = 48,
    parameter int MIN_LEN          = 64,
    parameter int MAX_LEN          = 1518
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LEN_WIDTH-1:0]        frame_len,
    input  logic                        frame_len_valid,
    input  logic                        snapshot_req,
    output logic [COUNT_WIDTH-1:0]      stat_frame_count,
    output logic [BYTE_COUNT_WIDTH-1:0] stat_byte_count,
    output logic [LEN_WIDTH-1:0]        stat_min_len,
    output logic [LEN_WIDTH-1:0]        stat_max_len,
    output logic [COUNT_WIDTH-1:0]      stat_runt_count,
    output logic [COUNT_WIDTH-1:0]      stat_oversize_count,
    output logic                        stat_valid,
    input  logic                        stat_ready
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MIN_LEN_L = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        logic [COUNT_WIDTH-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Saturating add of a zero-extended length to the byte total.
    function automatic logic [BYTE_COUNT_WIDTH-1:0] sat_add_len(
        input logic [BYTE_COUNT_WIDTH-1:0] acc,
        input logic [LEN_WIDTH-1:0]        len
    );
        logic [BYTE_COUNT_WIDTH:0]   sum;
        logic [BYTE_COUNT_WIDTH-1:0] r;
        sum = {1'b0, acc} + {{(BYTE_COUNT_WIDTH+1-LEN_WIDTH){1'b0}}, len};
        if (sum[BYTE_COUNT_WIDTH]) begin
            r = {BYTE_COUNT_WIDTH{1'b1}};
        end else begin
            r = sum[BYTE_COUNT_WIDTH-1:0];
        end
        return r;
    endfunction

    state_t                      state_r;
    state_t                      state_nxt_s;
    logic                        capture_s;
    logic                        valid_nxt_s;

    logic [COUNT_WIDTH-1:0]      acc_frame_r;
    logic [BYTE_COUNT_WIDTH-1:0] acc_byte_r;
    logic [LEN_WIDTH-1:0]        acc_min_r;
    logic [LEN_WIDTH-1:0]        acc_max_r;
    logic [COUNT_WIDTH-1:0]      acc_runt_r;
    logic [COUNT_WIDTH-1:0]      acc_over_r;

    logic [COUNT_WIDTH-1:0]      frame_nxt_s;
    logic [BYTE_COUNT_WIDTH-1:0] byte_nxt_s;
    logic [LEN_WIDTH-1:0]        min_nxt_s;
    logic [LEN_WIDTH-1:0]        max_nxt_s;
    logic [COUNT_WIDTH-1:0]      runt_nxt_s;
    logic [COUNT_WIDTH-1:0]      over_nxt_s;

    // Next-state and capture decode; requests in HOLD without ready are dropped.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        valid_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (snapshot_req) begin
                    capture_s   = 1'b1;
                    state_nxt_s = HOLD;
                    valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                    valid_nxt_s = 1'b0;
                end
            end
            HOLD: begin
                if (stat_ready) begin
                    if (snapshot_req) begin
                        capture_s   = 1'b1;
                        state_nxt_s = HOLD;
                        valid_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                        valid_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = HOLD;
                    valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                capture_s   = 1'b0;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Accumulator next-values including the frame strobed this cycle.
    always_comb begin
        frame_nxt_s = acc_frame_r;
        byte_nxt_s  = acc_byte_r;
        min_nxt_s   = acc_min_r;
        max_nxt_s   = acc_max_r;
        runt_nxt_s  = acc_runt_r;
        over_nxt_s  = acc_over_r;
        if (frame_len_valid) begin
            frame_nxt_s = sat_inc(acc_frame_r);
            byte_nxt_s  = sat_add_len(acc_byte_r, frame_len);
            if (frame_len < acc_min_r) begin
                min_nxt_s = frame_len;
            end else begin
                min_nxt_s = acc_min_r;
            end
            if (frame_len > acc_max_r) begin
                max_nxt_s = frame_len;
            end else begin
                max_nxt_s = acc_max_r;
            end
            if (frame_len < MIN_LEN_L) begin
                runt_nxt_s = sat_inc(acc_runt_r);
            end else begin
                runt_nxt_s = acc_runt_r;
            end
            if (frame_len > MAX_LEN_L) begin
                over_nxt_s = sat_inc(acc_over_r);
            end else begin
                over_nxt_s = acc_over_r;
            end
        end else begin
            frame_nxt_s = acc_frame_r;
        end
    end

    // State and handshake-valid registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            stat_valid <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            stat_valid <= valid_nxt_s;
        end
    end

    // Accumulators: clear on capture, otherwise take the next-values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_frame_r <= {COUNT_WIDTH{1'b0}};
            acc_byte_r  <= {BYTE_COUNT_WIDTH{1'b0}};
            acc_min_r   <= {LEN_WIDTH{1'b1}};
            acc_max_r   <= {LEN_WIDTH{1'b0}};
            acc_runt_r  <= {COUNT_WIDTH{1'b0}};
            acc_over_r  <= {COUNT_WIDTH{1'b0}};
        end else if (capture_s) begin
            acc_frame_r <= {COUNT_WIDTH{1'b0}};
            acc_byte_r  <= {BYTE_COUNT_WIDTH{1'b0}};
            acc_min_r   <= {LEN_WIDTH{1'b1}};
            acc_max_r   <= {LEN_WIDTH{1'b0}};
            acc_runt_r  <= {COUNT_WIDTH{1'b0}};
            acc_over_r  <= {COUNT_WIDTH{1'b0}};
        end else begin
            acc_frame_r <= frame_nxt_s;
            acc_byte_r  <= byte_nxt_s;
            acc_min_r   <= min_nxt_s;
            acc_max_r   <= max_nxt_s;
            acc_runt_r  <= runt_nxt_s;
            acc_over_r  <= over_nxt_s;
        end
    end

    // Snapshot registers: load on capture and hold until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_frame_count    <= {COUNT_WIDTH{1'b0}};
            stat_byte_count     <= {BYTE_COUNT_WIDTH{1'b0}};
            stat_min_len        <= {LEN_WIDTH{1'b0}};
            stat_max_len        <= {LEN_WIDTH{1'b0}};
            stat_runt_count     <= {COUNT_WIDTH{1'b0}};
            stat_oversize_count <= {COUNT_WIDTH{1'b0}};
        end else if (capture_s) begin
            stat_frame_count    <= frame_nxt_s;
            stat_byte_count     <= byte_nxt_s;
            // The min accumulator idles at all-ones; report 0 for an empty interval.
            stat_min_len        <= (frame_nxt_s == {COUNT_WIDTH{1'b0}}) ? {LEN_WIDTH{1'b0}} : min_nxt_s;
            stat_max_len        <= max_nxt_s;
            stat_runt_count     <= runt_nxt_s;
            stat_oversize_count <= over_nxt_s;
        end else begin
            stat_frame_count    <= stat_frame_count;
            stat_byte_count     <= stat_byte_count;
            stat_min_len        <= stat_min_len;
            stat_max_len        <= stat_max_len;
            stat_runt_count     <= stat_runt_count;
            stat_oversize_count <= stat_oversize_count;
        end
    end

endmodule

// File: tb/tb_axis_frame_len_stats.sv
// Directed testbench for axis_frame_len_stats, built with 4-bit counters so
// that counter saturation is reachable with a handful of frames.
module tb_axis_frame_len_stats;

    localparam int LW = 16;
    localparam int CW = 4;
    localparam int BW = 48;

    logic          clk;
    logic          rst;
    logic [LW-1:0] frame_len;
    logic          frame_len_valid;
    logic          snapshot_req;
    logic [CW-1:0] stat_frame_count;
    logic [BW-1:0] stat_byte_count;
    logic [LW-1:0] stat_min_len;
    logic [LW-1:0] stat_max_len;
    logic [CW-1:0] stat_runt_count;
    logic [CW-1:0] stat_oversize_count;
    logic          stat_valid;
    logic          stat_ready;

    int checks;
    int errors;

    axis_frame_len_stats #(
        .LEN_WIDTH(LW),
        .COUNT_WIDTH(CW),
        .BYTE_COUNT_WIDTH(BW),
        .MIN_LEN(64),
        .MAX_LEN(1518)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_len(frame_len),
        .frame_len_valid(frame_len_valid),
        .snapshot_req(snapshot_req),
        .stat_frame_count(stat_frame_count),
        .stat_byte_count(stat_byte_count),
        .stat_min_len(stat_min_len),
        .stat_max_len(stat_max_len),
        .stat_runt_count(stat_runt_count),
        .stat_oversize_count(stat_oversize_count),
        .stat_valid(stat_valid),
        .stat_ready(stat_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_snap(input string tag, input int v, input int cnt, input int bytes,
                            input int mn, input int mx, input int runt, input int over);
        chk({tag, "_valid"}, 64'(stat_valid), 64'(v));
        chk({tag, "_count"}, 64'(stat_frame_count), 64'(cnt));
        chk({tag, "_bytes"}, 64'(stat_byte_count), 64'(bytes));
        chk({tag, "_min"}, 64'(stat_min_len), 64'(mn));
        chk({tag, "_max"}, 64'(stat_max_len), 64'(mx));
        chk({tag, "_runt"}, 64'(stat_runt_count), 64'(runt));
        chk({tag, "_over"}, 64'(stat_oversize_count), 64'(over));
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        frame_len       = 16'd0;
        frame_len_valid = 1'b0;
        snapshot_req    = 1'b0;
        stat_ready      = 1'b0;
        tick();
        tick();
        chk_snap("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // Four frames covering runt, max-boundary and oversize lengths.
        frame_len_valid = 1'b1;
        frame_len = 16'd64;   tick();
        frame_len = 16'd1518; tick();
        frame_len = 16'd60;   tick();
        frame_len = 16'd1600; tick();
        frame_len_valid = 1'b0;
        snapshot_req = 1'b1;
        tick();
        snapshot_req = 1'b0;
        chk_snap("snap1", 1, 4, 3242, 60, 1600, 1, 1);

        // Transfer: valid drops, data holds.
        stat_ready = 1'b1;
        tick();
        stat_ready = 1'b0;
        chk("xfer_valid", 64'(stat_valid), 64'd0);
        chk("xfer_hold_count", 64'(stat_frame_count), 64'd4);

        // Frame in the request cycle is part of the snapshot.
        frame_len_valid = 1'b1;
        frame_len = 16'd200; tick();
        frame_len = 16'd200; tick();
        frame_len = 16'd100; snapshot_req = 1'b1; tick();
        frame_len_valid = 1'b0; snapshot_req = 1'b0;
        chk_snap("snap2", 1, 3, 500, 100, 200, 0, 0);
        stat_ready = 1'b1; tick();
        stat_ready = 1'b0; snapshot_req = 1'b1; tick();
        snapshot_req = 1'b0;
        chk_snap("snap_empty", 1, 0, 0, 0, 0, 0, 0);

        // HOLD without ready: requests dropped, accumulation continues.
        for (int i = 0; i < 10; i++) begin
            snapshot_req    = (i % 2 == 1);
            frame_len_valid = (i < 5);
            frame_len       = 16'd80;
            tick();
        end
        snapshot_req = 1'b0; frame_len_valid = 1'b0;
        chk_snap("hold_stable", 1, 0, 0, 0, 0, 0, 0);
        stat_ready = 1'b1; tick();
        chk("hold_release_valid", 64'(stat_valid), 64'd0);
        stat_ready = 1'b0; snapshot_req = 1'b1; tick();
        snapshot_req = 1'b0;
        chk_snap("snap3", 1, 5, 400, 80, 80, 0, 0);

        // Ready and request together in HOLD: back-to-back capture.
        stat_ready = 1'b1; snapshot_req = 1'b1; frame_len_valid = 1'b1; frame_len = 16'd90;
        tick();
        stat_ready = 1'b0; snapshot_req = 1'b0; frame_len_valid = 1'b0;
        chk_snap("b2b", 1, 1, 90, 90, 90, 0, 0);
        stat_ready = 1'b1; tick();
        stat_ready = 1'b0;

        // 17 runt frames: count and runt saturate at 15, bytes keep summing.
        frame_len_valid = 1'b1; frame_len = 16'd10;
        for (int i = 0; i < 17; i++) begin
            tick();
        end
        frame_len_valid = 1'b0; snapshot_req = 1'b1;
        tick();
        snapshot_req = 1'b0;
        chk_snap("sat", 1, 15, 170, 10, 10, 15, 0);

        // Asynchronous reset mid-HOLD, away from any clock edge.
        #2;
        rst = 1'b1;
        #1;
        chk_snap("async_rst", 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
